// File: rtl/cmi_mem_responder.sv
// cmi_mem_responder: memory-side responder for the CPU memory interconnect.
// Accepts one command per transaction, holds data in a longword array and
// returns status/read data after ACCESS_CYCLES, with a read-lock interlock.
// Optional build macro CMI_PARITY_EN adds byte parity on write and read data.
module cmi_mem_responder #(
  parameter int ADDR_W        = 16,
  parameter int MEM_WORDS     = 4096,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic              b_clk_l,
  input  logic              reset_h,
  input  logic              cmi_cmd_valid_h,
  input  logic [2:0]        cmi_func_h,
  input  logic [ADDR_W-1:0] cmi_addr_h,
  input  logic [31:0]       cmi_wdata_h,
  input  logic [3:0]        cmi_mask_h,
  output logic              cmi_busy_h,
  output logic              status_valid_l,
  output logic [31:0]       cmi_rdata_h,
  output logic [1:0]        cmi_status_h,
  output logic              lock_h
`ifdef CMI_PARITY_EN
  ,
  input  logic [3:0]        cmi_wpar_h,
  output logic [3:0]        cmi_rpar_h
`endif
);

  localparam int              IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [3:0]      WAIT_LOAD = 4'(ACCESS_CYCLES - 1);

  localparam logic [2:0] F_READ_LONG    = 3'b001;
  localparam logic [2:0] F_READ_LOCK    = 3'b010;
  localparam logic [2:0] F_WRITE_LONG   = 3'b101;
  localparam logic [2:0] F_WRITE_UNLOCK = 3'b110;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_NXM    = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;
  localparam logic [1:0] ST_BAD    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WDAT1, S_WAIT, S_RESP0, S_RESP1} state_t;

  // Odd parity per byte: parity bit makes byte plus parity contain an odd count of ones
  function automatic logic [3:0] odd_par(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ~^d[8*i +: 8];
    return p;
  endfunction

  // Byte-lane merge of new data into an old longword under a write mask
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r;
  logic [2:0]        func_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata0_r, wdata1_r;
  logic [3:0]        mask0_r, mask1_r;
  logic              wpar_err_r;
  logic [31:0]       mem_r [MEM_WORDS];

  logic              accept_s, is_long_s, enter_resp0_s, commit_s;
  logic [ADDR_W:0]   addr_next_s;
  logic [IDX_W-1:0]  idx0_s, idx1_s;
  logic [1:0]        status_s, status_nxt_s;
  logic              busy_nxt_s, svl_nxt_s, lock_nxt_s;
  logic [31:0]       rdata_nxt_s;

  assign accept_s      = cmi_cmd_valid_h && !cmi_busy_h && (state_r == S_IDLE);
  assign is_long_s     = (func_r == F_READ_LONG) || (func_r == F_WRITE_LONG);
  assign addr_next_s   = {1'b0, addr_r} + {{ADDR_W{1'b0}}, 1'b1};
  assign idx0_s        = addr_r[IDX_W-1:0];
  assign idx1_s        = addr_next_s[IDX_W-1:0];
  assign enter_resp0_s = (state_r == S_WAIT) && (cnt_r == 4'd0);
  assign commit_s      = enter_resp0_s && (status_s == ST_OK) && func_r[2] && !reset_h;

  // Response code for the captured command, in priority order BAD > NXM > LOCKED > OK
  always_comb begin
    status_s = ST_OK;
    if ((func_r[1:0] == 2'b11) || (func_r[2] && wpar_err_r)) begin
      status_s = ST_BAD;
    end else if (({1'b0, addr_r} >= MEM_LIMIT) || (is_long_s && (addr_next_s >= MEM_LIMIT))) begin
      status_s = ST_NXM;
    end else if ((func_r == F_READ_LOCK) && lock_h) begin
      status_s = ST_LOCKED;
    end else begin
      status_s = ST_OK;
    end
  end

  // State register and access-latency down-counter
  always_ff @(posedge b_clk_l) begin
    if (reset_h) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_nxt_s == S_WAIT) && (state_r != S_WAIT)) begin
        cnt_r <= WAIT_LOAD;
      end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Next-state logic of the transaction sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (cmi_func_h == F_WRITE_LONG) state_nxt_s = S_WDAT1;
          else                            state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WDAT1: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (cnt_r == 4'd0) state_nxt_s = S_RESP0;
        else               state_nxt_s = S_WAIT;
      end
      S_RESP0: begin
        if ((func_r == F_READ_LONG) && (cmi_status_h == ST_OK)) state_nxt_s = S_RESP1;
        else                                                    state_nxt_s = S_IDLE;
      end
      S_RESP1: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    busy_nxt_s   = (state_nxt_s != S_IDLE);
    svl_nxt_s    = !((state_nxt_s == S_RESP0) || (state_nxt_s == S_RESP1));
    rdata_nxt_s  = 32'h0;
    status_nxt_s = ST_OK;
    lock_nxt_s   = lock_h;
    if (enter_resp0_s) begin
      status_nxt_s = status_s;
      if ((status_s == ST_OK) && !func_r[2]) rdata_nxt_s = mem_r[idx0_s];
      else                                   rdata_nxt_s = 32'h0;
      if ((status_s == ST_OK) && (func_r == F_READ_LOCK))         lock_nxt_s = 1'b1;
      else if ((status_s == ST_OK) && (func_r == F_WRITE_UNLOCK)) lock_nxt_s = 1'b0;
      else                                                        lock_nxt_s = lock_h;
    end else if (state_nxt_s == S_RESP1) begin
      rdata_nxt_s = mem_r[idx1_s];
    end else begin
      rdata_nxt_s = 32'h0;
    end
  end

  // Output registers; reset drops any pending pulse and releases the interlock
  always_ff @(posedge b_clk_l) begin
    if (reset_h) begin
      cmi_busy_h     <= 1'b0;
      status_valid_l <= 1'b1;
      cmi_rdata_h    <= 32'h0;
      cmi_status_h   <= ST_OK;
      lock_h         <= 1'b0;
    end else begin
      cmi_busy_h     <= busy_nxt_s;
      status_valid_l <= svl_nxt_s;
      cmi_rdata_h    <= rdata_nxt_s;
      cmi_status_h   <= status_nxt_s;
      lock_h         <= lock_nxt_s;
    end
  end

  // Command capture on accept; second write longword taken one cycle later
  always_ff @(posedge b_clk_l) begin
    if (reset_h) begin
      func_r <= 3'b000;
      addr_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      func_r   <= cmi_func_h;
      addr_r   <= cmi_addr_h;
      wdata0_r <= cmi_wdata_h;
      mask0_r  <= cmi_mask_h;
    end
    if (state_r == S_WDAT1) begin
      wdata1_r <= cmi_wdata_h;
      mask1_r  <= cmi_mask_h;
    end
  end

  // Memory array: writes commit on entry to RESP0 only when the status is OK
  always_ff @(posedge b_clk_l) begin
    if (commit_s) begin
      mem_r[idx0_s] <= merge_bytes(mem_r[idx0_s], wdata0_r, mask0_r);
      if (func_r == F_WRITE_LONG) mem_r[idx1_s] <= merge_bytes(mem_r[idx1_s], wdata1_r, mask1_r);
    end
  end

`ifdef CMI_PARITY_EN
  // Accumulate write-parity errors on masked-in bytes of each captured longword
  always_ff @(posedge b_clk_l) begin
    if (reset_h) begin
      wpar_err_r <= 1'b0;
    end else if (accept_s) begin
      wpar_err_r <= |((odd_par(cmi_wdata_h) ^ cmi_wpar_h) & cmi_mask_h);
    end else if (state_r == S_WDAT1) begin
      wpar_err_r <= wpar_err_r || (|((odd_par(cmi_wdata_h) ^ cmi_wpar_h) & cmi_mask_h));
    end
  end

  // Read parity registered alongside read data (all ones while data is zero)
  always_ff @(posedge b_clk_l) begin
    if (reset_h) cmi_rpar_h <= 4'hF;
    else         cmi_rpar_h <= odd_par(rdata_nxt_s);
  end
`else
  assign wpar_err_r = 1'b0;
`endif

endmodule

// File: tb/tb_cmi_mem_responder.sv
// Scoreboard bench for cmi_mem_responder: a driver issues randomized and
// directed commands and pushes expected pulses computed from a word/byte
// memory model; an independent monitor pops and compares on every pulse.
module tb_cmi_mem_responder;
  localparam int ADDR_W        = 16;
  localparam int MEM_WORDS     = 4096;
  localparam int ACCESS_CYCLES = 3;

  logic              b_clk_l = 1'b0;
  logic              reset_h = 1'b1;
  logic              cmi_cmd_valid_h = 1'b0;
  logic [2:0]        cmi_func_h = 3'd0;
  logic [ADDR_W-1:0] cmi_addr_h = '0;
  logic [31:0]       cmi_wdata_h = 32'h0;
  logic [3:0]        cmi_mask_h = 4'h0;
  logic              cmi_busy_h, status_valid_l, lock_h;
  logic [31:0]       cmi_rdata_h;
  logic [1:0]        cmi_status_h;
`ifdef CMI_PARITY_EN
  logic [3:0]        cmi_wpar_h = 4'hF;
  logic [3:0]        cmi_rpar_h;
`endif

  cmi_mem_responder #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .ACCESS_CYCLES(ACCESS_CYCLES)) dut (
    .b_clk_l(b_clk_l), .reset_h(reset_h), .cmi_cmd_valid_h(cmi_cmd_valid_h),
    .cmi_func_h(cmi_func_h), .cmi_addr_h(cmi_addr_h), .cmi_wdata_h(cmi_wdata_h),
    .cmi_mask_h(cmi_mask_h), .cmi_busy_h(cmi_busy_h), .status_valid_l(status_valid_l),
    .cmi_rdata_h(cmi_rdata_h), .cmi_status_h(cmi_status_h), .lock_h(lock_h)
`ifdef CMI_PARITY_EN
    , .cmi_wpar_h(cmi_wpar_h), .cmi_rpar_h(cmi_rpar_h)
`endif
  );

  always #5 b_clk_l = ~b_clk_l;

  longint cyc = 0;
  always @(posedge b_clk_l) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] rd;
    logic [3:0]  known;
    longint      t;
    bit          last;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_data  [int];
  logic [3:0]  m_known [int];
  bit          m_lock = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Parity by counting ones in each byte
  function automatic logic [3:0] ref_odd_par(input logic [31:0] d);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) begin
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[8*b+i]);
      p[b] = ((ones % 2) == 0);
    end
    return p;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] d;
    logic [3:0]  k;
    d = m_data.exists(a) ? m_data[a] : 32'h0;
    k = m_known.exists(a) ? m_known[a] : 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        d[8*b +: 8] = wd[8*b +: 8];
        k[b] = 1'b1;
      end
    end
    m_data[a]  = d;
    m_known[a] = k;
  endfunction

  // Reference behaviour of one accepted command; t0 is the cycle count at drive time
  function automatic void model_cmd(input logic [2:0] f, input int a, input logic [31:0] wd0,
                                    input logic [3:0] m0, input logic [31:0] wd1,
                                    input logic [3:0] m1, input bit par_ok, input longint t0);
    exp_t e;
    bit   is_long, is_wr, bad, nxm;
    is_long = (f == 3'd1) || (f == 3'd5);
    is_wr   = f[2];
    bad     = (f == 3'd3) || (f == 3'd7) || (is_wr && !par_ok);
    nxm     = (a >= MEM_WORDS) || (is_long && (a + 1 >= MEM_WORDS));
    e.st    = bad ? 2'd3 : nxm ? 2'd1 : ((f == 3'd2) && m_lock) ? 2'd2 : 2'd0;
    e.t     = t0 + 1 + ACCESS_CYCLES + ((f == 3'd5) ? 1 : 0);
    e.rd    = 32'h0;
    e.known = 4'hF;
    e.last  = 1'b1;
    if (e.st == 2'd0) begin
      if (!is_wr) begin
        e.rd    = m_data.exists(a) ? m_data[a] : 32'h0;
        e.known = m_known.exists(a) ? m_known[a] : 4'h0;
        e.last  = (f != 3'd1);
      end else begin
        e.known = 4'h0;
        model_write(a, wd0, m0);
        if (f == 3'd5) model_write(a + 1, wd1, m1);
      end
      if (f == 3'd2) m_lock = 1'b1;
      if (f == 3'd6) m_lock = 1'b0;
    end
    exp_q.push_back(e);
    if ((e.st == 2'd0) && (f == 3'd1)) begin
      e.rd    = m_data.exists(a + 1) ? m_data[a + 1] : 32'h0;
      e.known = m_known.exists(a + 1) ? m_known[a + 1] : 4'h0;
      e.t     = e.t + 1;
      e.last  = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  // Returns at a falling edge with the DUT not busy, bounded by a cycle budget
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge b_clk_l);
    while (cmi_busy_h && (n < 500)) begin
      @(negedge b_clk_l);
      n++;
    end
    if (cmi_busy_h) begin
      n_cmp++;
      n_fail++;
      $display("FAIL busy_timeout: got busy=1 expected 0 after %0d cycles", n);
    end
  endtask

  // Issue one command; badb >= 0 corrupts the parity of that byte of the first longword
  task automatic send(input logic [2:0] f, input int a, input logic [31:0] wd0, input logic [3:0] m0,
                      input logic [31:0] wd1, input logic [3:0] m1, input int badb);
    bit par_ok;
    wait_idle();
    par_ok = !((badb >= 0) && m0[badb]);
    model_cmd(f, a, wd0, m0, wd1, m1, par_ok, cyc);
    cmi_cmd_valid_h = 1'b1;
    cmi_func_h      = f;
    cmi_addr_h      = a[ADDR_W-1:0];
    cmi_wdata_h     = wd0;
    cmi_mask_h      = m0;
`ifdef CMI_PARITY_EN
    cmi_wpar_h      = ref_odd_par(wd0) ^ ((badb >= 0) ? (4'b0001 << badb) : 4'b0000);
`endif
    @(negedge b_clk_l);
    cmi_cmd_valid_h = 1'b0;
    cmi_wdata_h     = wd1;
    cmi_mask_h      = m1;
`ifdef CMI_PARITY_EN
    cmi_wpar_h      = ref_odd_par(wd1);
`endif
  endtask

  // Monitor: compares every status pulse against the scoreboard head
  initial begin : monitor
    exp_t e;
    bit   chk_busy_low;
    chk_busy_low = 1'b0;
    forever begin
      @(negedge b_clk_l);
      if (reset_h) begin
        chk_busy_low = 1'b0;
      end else begin
        if (chk_busy_low) begin
          check("busy_after_last", 32'(cmi_busy_h), 32'd0);
          chk_busy_low = 1'b0;
        end
        if (!status_valid_l) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pulse: got status=%0d rdata=0x%08h expected no pulse", cmi_status_h, cmi_rdata_h);
          end else begin
            e = exp_q.pop_front();
            check("status", 32'(cmi_status_h), 32'(e.st));
            if (e.known != 4'h0) check("rdata", cmi_rdata_h & kmask(e.known), e.rd & kmask(e.known));
            check("pulse_cycle", 32'(cyc), 32'(e.t));
            check("busy_in_pulse", 32'(cmi_busy_h), 32'd1);
`ifdef CMI_PARITY_EN
            check("rpar", 32'(cmi_rpar_h), 32'(ref_odd_par(cmi_rdata_h)));
`endif
            if (e.last) chk_busy_low = 1'b1;
          end
        end else begin
          check("rdata_idle", cmi_rdata_h, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int tops[4];
    tops = '{4094, 4095, 4096, 65535};
    repeat (3) @(negedge b_clk_l);
    check("rst_busy", 32'(cmi_busy_h), 32'd0);
    check("rst_svl", 32'(status_valid_l), 32'd1);
    check("rst_rdata", cmi_rdata_h, 32'h0);
    check("rst_status", 32'(cmi_status_h), 32'd0);
    check("rst_lock", 32'(lock_h), 32'd0);
    reset_h = 1'b0;

    send(3'd4, 'h010, 32'hDEADBEEF, 4'hF, 32'h0, 4'h0, -1);
    send(3'd0, 'h010, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    send(3'd5, 'h020, 32'h11111111, 4'hF, 32'h22222222, 4'hF, -1);
    send(3'd1, 'h020, 32'h0, 4'h0, 32'h0, 4'h0, -1);

    send(3'd4, 'h030, 32'hCAFEF00D, 4'hF, 32'h0, 4'h0, -1);
    send(3'd2, 'h030, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    wait_idle();
    check("lock_set", 32'(lock_h), 32'(m_lock));
    send(3'd2, 'h030, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    send(3'd6, 'h030, 32'h0BADCAFE, 4'hF, 32'h0, 4'h0, -1);
    wait_idle();
    check("lock_clear", 32'(lock_h), 32'(m_lock));
    send(3'd6, 'h030, 32'h12340000, 4'hC, 32'h0, 4'h0, -1);
    send(3'd0, 'h030, 32'h0, 4'h0, 32'h0, 4'h0, -1);

    send(3'd1, MEM_WORDS - 1, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    send(3'd3, 'h010, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    send(3'd0, 'h010, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    cmi_cmd_valid_h = 1'b1;
    cmi_func_h      = 3'd4;
    cmi_addr_h      = 16'h0010;
    cmi_wdata_h     = 32'h0;
    cmi_mask_h      = 4'hF;
    repeat (2) @(negedge b_clk_l);
    cmi_cmd_valid_h = 1'b0;
    send(3'd0, 'h010, 32'h0, 4'h0, 32'h0, 4'h0, -1);

    send(3'd4, 'h040, 32'hFFFFFFFF, 4'hF, 32'h0, 4'h0, -1);
    send(3'd4, 'h040, 32'h0000AB00, 4'h2, 32'h0, 4'h0, -1);
    send(3'd0, 'h040, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    send(3'd2, 'h040, 32'h0, 4'h0, 32'h0, 4'h0, -1);
    wait_idle();
    cmi_cmd_valid_h = 1'b1;
    cmi_func_h      = 3'd4;
    cmi_addr_h      = 16'h0040;
    cmi_wdata_h     = 32'h12345678;
    cmi_mask_h      = 4'hF;
`ifdef CMI_PARITY_EN
    cmi_wpar_h      = ref_odd_par(32'h12345678);
`endif
    @(negedge b_clk_l);
    cmi_cmd_valid_h = 1'b0;
    reset_h         = 1'b1;
    @(negedge b_clk_l);
    m_lock = 1'b0;
    check("midrst_busy", 32'(cmi_busy_h), 32'd0);
    check("midrst_svl", 32'(status_valid_l), 32'd1);
    check("midrst_lock", 32'(lock_h), 32'(m_lock));
    reset_h = 1'b0;
    send(3'd0, 'h040, 32'h0, 4'h0, 32'h0, 4'h0, -1);

`ifdef CMI_PARITY_EN
    send(3'd4, 'h050, 32'h00000001, 4'hF, 32'h0, 4'h0, -1);
    send(3'd4, 'h050, 32'h5A5A5A5A, 4'hF, 32'h0, 4'h0, 1);
    send(3'd0, 'h050, 32'h0, 4'h0, 32'h0, 4'h0, -1);
`endif

    for (int k = 0; k < 200; k++) begin
      logic [2:0] f;
      int         a, bb;
      f  = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? tops[$urandom_range(0, 3)] : int'($urandom_range(0, 31));
      bb = -1;
`ifdef CMI_PARITY_EN
      if ($urandom_range(0, 9) == 0) bb = int'($urandom_range(0, 3));
`endif
      send(f, a, $urandom, 4'($urandom), $urandom, 4'($urandom), bb);
    end

    wait_idle();
    check("lock_final", 32'(lock_h), 32'(m_lock));
    repeat (5) @(negedge b_clk_l);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
